// File: rtl/egress_arbiter.sv
// -----------------------------------------------------------------------------
// egress_arbiter
//
// Collects single-cycle write requests from NUM_PORTS ingress ports that target
// one egress port. Each ingress has one holding slot (pending flag + captured
// start pointer). A round-robin arbiter moves one pending pointer per cycle
// into a first-word-fall-through pointer queue, which the egress consumer
// drains with a valid/ready handshake. A request that arrives while its slot
// is still occupied (and that slot is not being granted in the same cycle) is
// dropped; this is reported by a one-cycle pulse on drop_o and counted in a
// saturating 16-bit counter.
//
// Ports
//   clk           single clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   req_i         per-ingress single-cycle request
//   start_ptr_i   per-ingress start pointer, ingress k at [k*ADDR_W +: ADDR_W]
//   ptr_o         queue-head start pointer (meaningful only when ptr_valid_o)
//   ptr_valid_o   queue is non-empty
//   ptr_ready_i   consumer accepts ptr_o this cycle
//   full_o        queue holds FIFO_DEPTH entries
//   drop_o        registered one-cycle pulse per ingress whose request was lost
//   drop_count_o  saturating total of dropped requests
// -----------------------------------------------------------------------------

package switch_pkg;
  localparam int NUM_PORTS = 4;
endpackage

package mem_pkg;
  localparam int ADDR_W = 8;
endpackage

module egress_arbiter #(
  parameter int NUM_PORTS  = switch_pkg::NUM_PORTS,
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] start_ptr_i,
  output logic [ADDR_W-1:0]           ptr_o,
  output logic                        ptr_valid_o,
  input  logic                        ptr_ready_i,
  output logic                        full_o,
  output logic [NUM_PORTS-1:0]        drop_o,
  output logic [15:0]                 drop_count_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int POP_W = $clog2(NUM_PORTS + 1);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  // Holding slots
  logic [NUM_PORTS-1:0] pending_reg;
  logic [NUM_PORTS-1:0] pending_next;
  logic [NUM_PORTS-1:0] capture;
  logic [ADDR_W-1:0]    held_ptr_reg [NUM_PORTS];

  // Arbiter
  logic [IDX_W-1:0]     last_grant_reg;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic [ADDR_W-1:0]    grant_ptr;
  int                   cand;

  // Drop reporting
  logic [NUM_PORTS-1:0] drop_reg;
  logic [NUM_PORTS-1:0] drop_next;
  logic [POP_W-1:0]     drop_sum;
  logic [16:0]          drop_total;
  logic [15:0]          drop_count_reg;
  logic [15:0]          drop_count_next;

  // Pointer queue
  logic [ADDR_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     count_next;
  logic                 push;
  logic                 pop;

  // ---------------------------------------------------------------------------
  // Round-robin selection: search from last_grant+1 upward, wrapping. A full
  // queue blocks the grant even when a pop happens in the same cycle, so the
  // decision depends on registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (count_reg != DEPTH_C) begin
      for (int off = 1; off <= NUM_PORTS; off++) begin
        cand = int'(last_grant_reg) + off;
        if (cand >= NUM_PORTS) begin
          cand = cand - NUM_PORTS;
        end
        if (!grant_valid && pending_reg[IDX_W'(cand)]) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(cand);
        end
      end
    end
  end

  assign grant_ptr = held_ptr_reg[grant_idx];
  assign push      = grant_valid;
  assign pop       = ptr_valid_o && ptr_ready_i;

  // ---------------------------------------------------------------------------
  // Per-ingress slot control. A slot that is granted this cycle counts as free,
  // so a same-cycle re-request is captured rather than dropped.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
    logic granted;
    assign granted          = grant_valid && (grant_idx == IDX_W'(gi));
    assign capture[gi]      = req_i[gi] && (!pending_reg[gi] || granted);
    assign drop_next[gi]    = req_i[gi] && pending_reg[gi] && !granted;
    assign pending_next[gi] = capture[gi] ? 1'b1 :
                              (granted ? 1'b0 : pending_reg[gi]);
  end

  // Held pointers carry no reset; pending_reg qualifies them.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (capture[k]) begin
        held_ptr_reg[k] <= start_ptr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter: add this cycle's drops, clamp at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    drop_sum = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      drop_sum = drop_sum + POP_W'(drop_next[k]);
    end
  end

  assign drop_total      = {1'b0, drop_count_reg} + 17'(drop_sum);
  assign drop_count_next = drop_total[16] ? 16'hFFFF : drop_total[15:0];

  // ---------------------------------------------------------------------------
  // Queue occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Queue storage carries no reset; count_reg qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= grant_ptr;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg    <= '0;
      last_grant_reg <= LAST_RST;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      drop_reg       <= '0;
      drop_count_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      if (grant_valid) begin
        last_grant_reg <= grant_idx;
      end
      // Depth is a power of two, so the pointers wrap by natural overflow.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg      <= count_next;
      drop_reg       <= drop_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // First-word fall-through head
  assign ptr_o        = fifo_mem[rd_ptr_reg];
  assign ptr_valid_o  = (count_reg != '0);
  assign full_o       = (count_reg == DEPTH_C);
  assign drop_o       = drop_reg;
  assign drop_count_o = drop_count_reg;

endmodule

// File: tb/tb_egress_arbiter.sv
// -----------------------------------------------------------------------------
// tb_egress_arbiter
//
// Self-checking bench for egress_arbiter: a table of directed vectors, a few
// hand-written multi-cycle sequences, and a randomized run, all compared every
// cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_egress_arbiter;

  localparam int NP = 4;
  localparam int AW = 8;
  localparam int D  = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NP-1:0]        req_i;
  logic [NP*AW-1:0]     start_ptr_i;
  logic [AW-1:0]        ptr_o;
  logic                 ptr_valid_o;
  logic                 ptr_ready_i;
  logic                 full_o;
  logic [NP-1:0]        drop_o;
  logic [15:0]          drop_count_o;

  egress_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_W     (AW),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .start_ptr_i  (start_ptr_i),
    .ptr_o        (ptr_o),
    .ptr_valid_o  (ptr_valid_o),
    .ptr_ready_i  (ptr_ready_i),
    .full_o       (full_o),
    .drop_o       (drop_o),
    .drop_count_o (drop_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: slots as flags + pointers, queue as an SV queue.
  // ---------------------------------------------------------------------------
  logic [NP-1:0] m_pend;
  logic [AW-1:0] m_held [NP];
  logic [AW-1:0] m_q [$];
  int            m_last;
  logic [NP-1:0] m_drop;
  int            m_cnt;

  task automatic model_reset();
    m_pend = '0;
    m_q.delete();
    m_last = NP - 1;
    m_drop = '0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [NP-1:0] req, input logic [NP*AW-1:0] ptrs, input logic rdy);
    int g;
    bit do_pop;
    g = -1;
    do_pop = (m_q.size() != 0) && rdy;
    if (m_pend != '0 && m_q.size() < D) begin
      for (int off = 1; off <= NP; off++) begin
        int k;
        k = (m_last + off) % NP;
        if (g < 0 && m_pend[k]) g = k;
      end
    end
    m_drop = '0;
    for (int k = 0; k < NP; k++) begin
      if (req[k] && m_pend[k] && k != g) m_drop[k] = 1'b1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(m_held[g]);
      m_pend[g] = 1'b0;
      m_last = g;
    end
    for (int k = 0; k < NP; k++) begin
      if (req[k] && !m_pend[k]) begin
        m_pend[k] = 1'b1;
        m_held[k] = ptrs[k*AW +: AW];
      end
    end
    m_cnt = m_cnt + $countones(m_drop);
    if (m_cnt > 65535) m_cnt = 65535;
  endtask

  task automatic check_model();
    chk("valid", ptr_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) chk("ptr", ptr_o, m_q[0]);
    chk("full", full_o, m_q.size() == D);
    chk("drop", drop_o, m_drop);
    chk("drop_count", drop_count_o, m_cnt);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [AW-1:0] popped [$];

  function automatic logic [NP*AW-1:0] mk(input logic [AW-1:0] base, input logic [AW-1:0] stride);
    logic [NP*AW-1:0] r;
    for (int k = 0; k < NP; k++) begin
      r[k*AW +: AW] = base + AW'(k) * stride;
    end
    return r;
  endfunction

  // Entered and left at posedge+1.
  task automatic cycle(input logic [NP-1:0] req, input logic [NP*AW-1:0] ptrs, input logic rdy);
    req_i       = req;
    start_ptr_i = ptrs;
    ptr_ready_i = rdy;
    if (ptr_valid_o && rdy) begin
      popped.push_back(ptr_o);
      $display("POP ptr=%02h t=%0t", ptr_o, $time);
    end
    @(posedge clk);
    model_step(req, ptrs, rdy);
    #1;
    check_model();
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", ptr_valid_o, 1'b0);
    chk("rst_full", full_o, 1'b0);
    chk("rst_drop", drop_o, '0);
    chk("rst_count", drop_count_o, 16'd0);
    model_reset();
    req_i       = '0;
    ptr_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            rst;
    logic [NP-1:0] req;
    logic [AW-1:0] base;
    logic          rdy;
    logic          ev;
    logic [AW-1:0] ep;
    logic          ef;
    logic [NP-1:0] ed;
    logic [15:0]   ec;
  } vec_t;

  vec_t tbl [13];

  initial begin
    rst_n       = 1'b1;
    req_i       = '0;
    start_ptr_i = '0;
    ptr_ready_i = 1'b0;
    model_reset();

    // Single request, simultaneous requests in order, grant-and-rerequest.
    tbl[0]  = '{0, 4'b0100, 8'h0E, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0};
    tbl[1]  = '{0, 4'b0000, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 4'b0000, 16'd0};
    tbl[2]  = '{0, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0};
    tbl[3]  = '{1, 4'b1111, 8'hA0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0};
    tbl[4]  = '{0, 4'b0000, 8'h00, 1'b1, 1'b1, 8'hA0, 1'b0, 4'b0000, 16'd0};
    tbl[5]  = '{0, 4'b0000, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b0, 4'b0000, 16'd0};
    tbl[6]  = '{0, 4'b0000, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b0, 4'b0000, 16'd0};
    tbl[7]  = '{0, 4'b0000, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b0, 4'b0000, 16'd0};
    tbl[8]  = '{0, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0};
    tbl[9]  = '{0, 4'b0010, 8'h30, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0};
    tbl[10] = '{0, 4'b0010, 8'h40, 1'b1, 1'b1, 8'h31, 1'b0, 4'b0000, 16'd0};
    tbl[11] = '{0, 4'b0000, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 4'b0000, 16'd0};
    tbl[12] = '{0, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0};

    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].req, mk(tbl[i].base, 8'd1), tbl[i].rdy);
      chk($sformatf("tv%0d_valid", i), ptr_valid_o, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tv%0d_ptr", i), ptr_o, tbl[i].ep);
      chk($sformatf("tv%0d_full", i), full_o, tbl[i].ef);
      chk($sformatf("tv%0d_drop", i), drop_o, tbl[i].ed);
      chk($sformatf("tv%0d_count", i), drop_count_o, tbl[i].ec);
    end

    // Back-pressure: six back-to-back requests on port 0 with ready low.
    do_reset();
    popped.delete();
    for (int i = 1; i <= 6; i++) begin
      cycle(4'b0001, mk(8'h50 + AW'(i), 8'd0), 1'b0);
      chk("bp_full", full_o, i >= 5);
    end
    chk("bp_drop", drop_o, 4'b0001);
    chk("bp_drop_count", drop_count_o, 16'd1);
    for (int i = 0; i < 8; i++) cycle('0, '0, 1'b1);
    chk("bp_drain_n", popped.size(), 5);
    for (int j = 0; j < popped.size() && j < 5; j++) begin
      chk("bp_order", popped[j], 8'h51 + AW'(j));
    end

    // Round-robin fairness: ports 0 and 3 request every cycle.
    do_reset();
    popped.delete();
    for (int c = 0; c < 10; c++) cycle(4'b1001, mk(AW'(c), 8'h10), 1'b1);
    chk("rr_n", popped.size() >= 6, 1'b1);
    for (int j = 0; j < popped.size() && j < 6; j++) begin
      chk("rr_port", popped[j][7:4], (j % 2 == 1) ? 4'd3 : 4'd0);
    end

    // Saturation: all ports hammer a full queue for about 70000 drops.
    do_reset();
    for (int n = 0; n < 17500; n++) cycle(4'b1111, mk(AW'(n), 8'd1), 1'b0);
    chk("sat_reached", drop_count_o, 16'hFFFF);
    for (int n = 0; n < 5; n++) cycle(4'b1111, mk(8'h00, 8'd1), 1'b0);
    chk("sat_hold", drop_count_o, 16'hFFFF);
    chk("pre_rst_full", full_o, 1'b1);

    // Reset mid-queue: nothing emitted afterward until new requests; port 0 first.
    do_reset();
    popped.delete();
    for (int n = 0; n < 3; n++) cycle('0, '0, 1'b1);
    chk("post_rst_quiet", popped.size(), 0);
    cycle(4'b1011, mk(8'hC0, 8'd1), 1'b1);
    for (int n = 0; n < 5; n++) cycle('0, '0, 1'b1);
    chk("post_rst_n", popped.size(), 3);
    if (popped.size() > 0) chk("post_rst_first", popped[0], 8'hC0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [NP-1:0] r;
      r = NP'($urandom & $urandom);
      cycle(r, ($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/egress_arbiter.md
EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default switch_pkg::NUM_PORTS, number of ingress requesters.
REQ-002 Parameter ADDR_W, default mem_pkg::ADDR_W, packet start-pointer width.
REQ-003 Parameter FIFO_DEPTH, default 4, pointer-queue entries, power of two, >= 2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_i  input  NUM_PORTS  per-ingress single-cycle write request for this egress port.
REQ-007 start_ptr_i  input  ADDR_W x NUM_PORTS  start pointer paired with each req_i bit.
REQ-008 ptr_o  output  ADDR_W  queue-head start pointer.
REQ-009 ptr_valid_o  output  1  ptr_o holds a valid entry.
REQ-010 ptr_ready_i  input  1  egress consumer accepts ptr_o.
REQ-011 full_o  output  1  queue holds FIFO_DEPTH entries.
REQ-012 drop_o  output  NUM_PORTS  registered one-cycle pulse per ingress whose request was lost.
REQ-013 drop_count_o  output  16  saturating total of dropped requests.

Function
REQ-014 Each ingress owns one holding slot: pending flag plus ADDR_W pointer register.
REQ-015 req_i[k] with slot k empty, or emptied by a grant in the same cycle: set pending[k] and capture start_ptr_i[k] at the edge.
REQ-016 req_i[k] with pending[k] set and k not granted in that cycle: request dropped; held pointer unchanged; drop_o[k] = 1 for the following cycle.
REQ-017 drop_count_o adds the number of set drop bits per cycle; saturates at 16'hFFFF, never wraps.
REQ-018 Grant: when any pending bit is set and queue count < FIFO_DEPTH, grant exactly one ingress per cycle.
REQ-019 Grant selection: round-robin, search starting at last_grant+1 modulo NUM_PORTS; last_grant updates only on a grant.
REQ-020 Grant action: push the granted slot's pointer at the queue tail and clear its pending flag at the same edge.
REQ-021 Queue full (count == FIFO_DEPTH): no grant, even if a pop occurs that cycle; pending slots hold.
REQ-022 Queue is first-word fall-through: ptr_o = head entry; ptr_valid_o = (count != 0).
REQ-023 Pop when ptr_valid_o and ptr_ready_i; ptr_o is undefined-but-stable-irrelevant when ptr_valid_o = 0.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance; read/write pointers wrap modulo FIFO_DEPTH.
REQ-025 full_o = (count == FIFO_DEPTH), combinational from count.
REQ-026 Latency: uncontended req_i at edge t gives pending at t; grant and push at edge t+1; ptr_valid_o high after edge t+1 (two edges from request to valid).
REQ-027 Order preserved: pointers leave in grant order; each accepted request is emitted exactly once.

Reset
REQ-028 rst_n low clears immediately, regardless of clk: all pending flags, queue count and read/write pointers, drop_o, and drop_count_o.
REQ-029 During reset, last_grant = NUM_PORTS-1, so ingress 0 holds first priority after reset.
REQ-030 Reset outputs: ptr_valid_o = 0, full_o = 0, drop_o = 0, drop_count_o = 0.
REQ-031 Held pointer and queue storage need no reset.
REQ-032 Reset mid-operation discards all queued and pending pointers; no pointer is emitted after release until a new req_i.

Verification
REQ-033 Single request: req_i[2] = 1, ptr = 0x10, ready = 1 -> ptr_valid_o after 2 edges, ptr_o = 0x10, one-cycle valid.
REQ-034 Simultaneous requests: all req_i = 1 with ptrs 0xA0+k, ready = 1 -> ptrs emitted in order 0xA0, 0xA1, ..., one per cycle, no drops.
REQ-035 Back-pressure: ready = 0, 6 sequential requests, FIFO_DEPTH = 4 -> full_o = 1 after 4 pushes; 5th request held pending; 6th on same port asserts drop_o and drop_count_o = 1; raise ready -> 5 pointers drained in order.
REQ-036 Round-robin fairness: ports 0 and 3 re-request every cycle -> grants alternate 0, 3, 0, 3.
REQ-037 Grant-and-rerequest: req_i[1] in the same cycle slot 1 is granted -> new pointer captured, no drop.
REQ-038 Saturation and reset: force 70000 drops -> drop_count_o = 0xFFFF; assert rst_n mid-queue -> all outputs zero immediately, port 0 granted first after release.
